// File: rtl/me_frame_feeder_if.sv
// Load/control/result bundle between a host and the motion-estimation frame
// feeder: beat handshake, sweep request, busy flag and captured core result.
interface me_frame_feeder_if;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic        start;
  logic        busy;
  logic        res_valid;
  logic [13:0] res_sad;
  logic [3:0]  res_mvx;
  logic [3:0]  res_mvy;

  // Feeder side.
  modport slave (
    input  ld_valid, ld_data, start,
    output ld_ready, busy, res_valid, res_sad, res_mvx, res_mvy
  );

  // Host side.
  modport master (
    output ld_valid, ld_data, start,
    input  ld_ready, busy, res_valid, res_sad, res_mvx, res_mvy
  );
endinterface

// File: rtl/me_frame_feeder.sv
// Motion-estimation frame feeder: buffers one 8-row current block and a
// 23-row x 24-pixel search window from a beat stream, then replays them to
// 16 SAD PEs over a 25-phase sweep locked to the core's phase counter, and
// captures the core's best SAD / motion vector at the last phase.
module me_frame_feeder #(
  parameter int NBEATS = 77
) (
  input  logic        clk,
  input  logic        rst,
  me_frame_feeder_if.slave ld,
  output logic        core_rst,
  output logic [63:0] crt_frame_0,  crt_frame_1,  crt_frame_2,  crt_frame_3,
  output logic [63:0] crt_frame_4,  crt_frame_5,  crt_frame_6,  crt_frame_7,
  output logic [63:0] crt_frame_8,  crt_frame_9,  crt_frame_10, crt_frame_11,
  output logic [63:0] crt_frame_12, crt_frame_13, crt_frame_14, crt_frame_15,
  output logic [63:0] pre_frame_0,  pre_frame_1,  pre_frame_2,  pre_frame_3,
  output logic [63:0] pre_frame_4,  pre_frame_5,  pre_frame_6,  pre_frame_7,
  output logic [63:0] pre_frame_8,  pre_frame_9,  pre_frame_10, pre_frame_11,
  output logic [63:0] pre_frame_12, pre_frame_13, pre_frame_14, pre_frame_15,
  input  logic [13:0] core_sad,
  input  logic [3:0]  core_mvx,
  input  logic [3:0]  core_mvy
);

  localparam int NCUR   = 8;                 // current-block rows
  localparam int NWIN   = NBEATS - NCUR;     // window words (3 per row)
  localparam int NPE    = 16;
  localparam int BW     = $clog2(NBEATS);
  localparam int WIN_AW = $clog2(NWIN);
  localparam logic [4:0] LAST_PHASE = 5'd24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_SWEEP
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     b_q, b_d;              // accepted-beat index
  logic [4:0]        p_q, p_d;              // sweep phase
  logic              ld_ready_q, ld_ready_d;
  logic              busy_q, busy_d;
  logic              core_rst_q, core_rst_d;
  logic              res_valid_q, res_valid_d;
  logic [13:0]       res_sad_q, res_sad_d;
  logic [3:0]        res_mvx_q, res_mvx_d;
  logic [3:0]        res_mvy_q, res_mvy_d;
  logic [63:0]       crt_q, crt_d;          // identical for every PE
  logic [63:0]       pre_q [NPE];
  logic [63:0]       pre_d [NPE];
  logic [3:0]        win_x;                 // first window pixel of the slice

  logic [63:0]       cur_mem [NCUR];
  logic [63:0]       win_mem [NWIN];        // row r word w at index 3r+w

  logic              accept;

  assign accept = ld.ld_valid && ld_ready_q;

  // Eight pixels starting at pixel x of window row `row` (pixel x -> [7:0]).
  function automatic logic [63:0] win_slice(input logic [4:0] row,
                                            input logic [3:0] x);
    logic [WIN_AW-1:0] base;
    logic [191:0]      row_bits;
    base     = WIN_AW'({row, 1'b0}) + WIN_AW'(row);
    row_bits = {win_mem[base + WIN_AW'(2)], win_mem[base + WIN_AW'(1)],
                win_mem[base]};
    return 64'(row_bits >> {x, 3'b000});
  endfunction

  // Next-state, handshake, result capture and next PE-frame selection.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    b_d         = b_q;
    p_d         = p_q;
    res_valid_d = 1'b0;
    res_sad_d   = res_sad_q;
    res_mvx_d   = res_mvx_q;
    res_mvy_d   = res_mvy_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          b_d     = BW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (b_q == BW'(NBEATS - 1)) begin
            b_d     = '0;
            state_d = S_FULL;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      S_FULL: begin
        if (ld.start) begin
          p_d     = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (p_q == LAST_PHASE) begin
          p_d         = '0;
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          res_sad_d   = core_sad;
          res_mvx_d   = core_mvx;
          res_mvy_d   = core_mvy;
        end else begin
          p_d = p_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ld_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    core_rst_d = (state_d != S_SWEEP);

    // Frames are computed for the phase the core will see next cycle.
    win_x = (p_d < 5'd8) ? 4'd0 : 4'(p_d - 5'd8);
    crt_d = '0;
    for (int k = 0; k < NPE; k++) pre_d[k] = '0;
    if (state_d == S_SWEEP) begin
      crt_d = cur_mem[(p_d < 5'd8) ? p_d[2:0] : 3'd7];
      if (p_d != LAST_PHASE) begin
        for (int k = 0; k < NPE; k++)
          pre_d[k] = win_slice(5'(k) + {2'b00, p_d[2:0]}, win_x);
      end
    end
  end

  // Control, result and frame-output registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      p_q         <= '0;
      ld_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      core_rst_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_sad_q   <= '0;
      res_mvx_q   <= '0;
      res_mvy_q   <= '0;
      crt_q       <= '0;
      for (int k = 0; k < NPE; k++) pre_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      p_q         <= p_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      core_rst_q  <= core_rst_d;
      res_valid_q <= res_valid_d;
      res_sad_q   <= res_sad_d;
      res_mvx_q   <= res_mvx_d;
      res_mvy_q   <= res_mvy_d;
      crt_q       <= crt_d;
      for (int k = 0; k < NPE; k++) pre_q[k] <= pre_d[k];
    end
  end

  // Beat storage: first NCUR beats are current rows, the rest window words.
  always_ff @(posedge clk) begin
    // NOTE: the buffers have no reset; they are always fully rewritten by a
    // load before a sweep can read them, and frame outputs are zero otherwise.
    if (accept) begin
      if (b_q < BW'(NCUR)) cur_mem[b_q[2:0]] <= ld.ld_data;
      else                 win_mem[WIN_AW'(b_q - BW'(NCUR))] <= ld.ld_data;
    end
  end

  assign ld.ld_ready  = ld_ready_q;
  assign ld.busy      = busy_q;
  assign ld.res_valid = res_valid_q;
  assign ld.res_sad   = res_sad_q;
  assign ld.res_mvx   = res_mvx_q;
  assign ld.res_mvy   = res_mvy_q;
  assign core_rst     = core_rst_q;

  assign crt_frame_0  = crt_q;
  assign crt_frame_1  = crt_q;
  assign crt_frame_2  = crt_q;
  assign crt_frame_3  = crt_q;
  assign crt_frame_4  = crt_q;
  assign crt_frame_5  = crt_q;
  assign crt_frame_6  = crt_q;
  assign crt_frame_7  = crt_q;
  assign crt_frame_8  = crt_q;
  assign crt_frame_9  = crt_q;
  assign crt_frame_10 = crt_q;
  assign crt_frame_11 = crt_q;
  assign crt_frame_12 = crt_q;
  assign crt_frame_13 = crt_q;
  assign crt_frame_14 = crt_q;
  assign crt_frame_15 = crt_q;

  assign pre_frame_0  = pre_q[0];
  assign pre_frame_1  = pre_q[1];
  assign pre_frame_2  = pre_q[2];
  assign pre_frame_3  = pre_q[3];
  assign pre_frame_4  = pre_q[4];
  assign pre_frame_5  = pre_q[5];
  assign pre_frame_6  = pre_q[6];
  assign pre_frame_7  = pre_q[7];
  assign pre_frame_8  = pre_q[8];
  assign pre_frame_9  = pre_q[9];
  assign pre_frame_10 = pre_q[10];
  assign pre_frame_11 = pre_q[11];
  assign pre_frame_12 = pre_q[12];
  assign pre_frame_13 = pre_q[13];
  assign pre_frame_14 = pre_q[14];
  assign pre_frame_15 = pre_q[15];

endmodule

// File: tb/tb_me_frame_feeder.sv
// Self-checking bench for me_frame_feeder: directed loads and sweeps with a
// scoreboard of expected per-phase PE frames and captured core results.
module tb_me_frame_feeder;
  localparam int NBEATS = 77;

  typedef logic [16:0][63:0] frame_t;   // [15:0] pre_frame_k, [16] crt_frame
  typedef struct packed {
    logic [13:0] sad;
    logic [3:0]  mvx;
    logic [3:0]  mvy;
    logic [31:0] cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rst;
  logic [63:0] crt_w [16];
  logic [63:0] pre_w [16];
  logic [13:0] core_sad;
  logic [3:0]  core_mvx, core_mvy;

  me_frame_feeder_if ld_if ();

  always #5 clk = ~clk;

  me_frame_feeder #(.NBEATS(NBEATS)) dut (
    .clk(clk), .rst(rst), .ld(ld_if), .core_rst(core_rst),
    .crt_frame_0(crt_w[0]),   .crt_frame_1(crt_w[1]),   .crt_frame_2(crt_w[2]),
    .crt_frame_3(crt_w[3]),   .crt_frame_4(crt_w[4]),   .crt_frame_5(crt_w[5]),
    .crt_frame_6(crt_w[6]),   .crt_frame_7(crt_w[7]),   .crt_frame_8(crt_w[8]),
    .crt_frame_9(crt_w[9]),   .crt_frame_10(crt_w[10]), .crt_frame_11(crt_w[11]),
    .crt_frame_12(crt_w[12]), .crt_frame_13(crt_w[13]), .crt_frame_14(crt_w[14]),
    .crt_frame_15(crt_w[15]),
    .pre_frame_0(pre_w[0]),   .pre_frame_1(pre_w[1]),   .pre_frame_2(pre_w[2]),
    .pre_frame_3(pre_w[3]),   .pre_frame_4(pre_w[4]),   .pre_frame_5(pre_w[5]),
    .pre_frame_6(pre_w[6]),   .pre_frame_7(pre_w[7]),   .pre_frame_8(pre_w[8]),
    .pre_frame_9(pre_w[9]),   .pre_frame_10(pre_w[10]), .pre_frame_11(pre_w[11]),
    .pre_frame_12(pre_w[12]), .pre_frame_13(pre_w[13]), .pre_frame_14(pre_w[14]),
    .pre_frame_15(pre_w[15]),
    .core_sad(core_sad), .core_mvx(core_mvx), .core_mvy(core_mvy)
  );

  // Cycle counter and core model: phase counter held at 0 by core_rst, result
  // presented only in phase 24 so a mis-timed capture reads zeros.
  int          cyc = 0;
  int          core_cnt;
  logic [13:0] cfg_sad;
  logic [3:0]  cfg_mvx, cfg_mvy;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else          core_cnt <= (core_cnt == 24) ? 0 : core_cnt + 1;
  end
  assign core_sad = (core_cnt == 24) ? cfg_sad : 14'h0;
  assign core_mvx = (core_cnt == 24) ? cfg_mvx : 4'h0;
  assign core_mvy = (core_cnt == 24) ? cfg_mvy : 4'h0;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     mon_en  = 1'b0;
  frame_t exp_fq [$];
  res_t   exp_rq [$];

  logic [63:0] cur_ref [8];
  logic [7:0]  win_ref [23][24];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference job data: job 0 is the hand-specified pattern.
  task automatic fill_pattern(input int job);
    for (int r = 0; r < 8; r++) begin
      if (job == 0) cur_ref[r] = 64'h0101_0101_0101_0101 * 64'(r + 1);
      else for (int j = 0; j < 8; j++) cur_ref[r][8*j +: 8] = 8'(r * 16 + j + 48);
    end
    for (int r = 0; r < 23; r++)
      for (int c = 0; c < 24; c++)
        win_ref[r][c] = (job == 0) ? 8'((r * 23 + c) % 256)
                                   : 8'((r * 37 + c * 11 + 5) % 256);
  endtask

  function automatic logic [63:0] beat_of(input int b);
    logic [63:0] d;
    int i;
    if (b < 8) return cur_ref[b];
    i = b - 8;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = win_ref[i / 3][8 * (i % 3) + j];
    return d;
  endfunction

  function automatic frame_t exp_frame(input int p);
    frame_t f;
    int     x;
    f     = '0;
    f[16] = cur_ref[(p < 8) ? p : 7];
    if (p != 24) begin
      x = (p < 8) ? 0 : p - 8;
      for (int k = 0; k < 16; k++)
        for (int j = 0; j < 8; j++) f[k][8*j +: 8] = win_ref[k + p % 8][x + j];
    end
    return f;
  endfunction

  // Offer NBEATS beats; optional one-cycle start when beat index start_at is offered.
  task automatic load_job(input bit random_valid, input int start_at);
    int idx   = 0;
    int guard = 0;
    bit acc;
    while (idx < NBEATS && guard < 2000) begin
      ld_if.ld_valid = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_if.ld_data  = ld_if.ld_valid ? beat_of(idx) : 64'hDEAD_BEEF_DEAD_BEEF;
      ld_if.start    = (idx == start_at);
      acc            = ld_if.ld_valid && ld_if.ld_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    ld_if.ld_valid = 1'b0;
    ld_if.start    = 1'b0;
    check("load_beats_accepted", 64'(idx), 64'(NBEATS));
    check("full_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("full_busy", 64'(ld_if.busy), 64'(1));
    check("full_core_rst", 64'(core_rst), 64'(1));
  endtask

  task automatic start_sweep(input bit expect_res);
    int sc;
    sc = cyc + 1;
    for (int p = 0; p < 25; p++) exp_fq.push_back(exp_frame(p));
    if (expect_res)
      exp_rq.push_back('{sad: cfg_sad, mvx: cfg_mvx, mvy: cfg_mvy, cyc: 32'(sc + 25)});
    ld_if.start = 1'b1;
    tick();
    ld_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (ld_if.busy && g < 60) begin
      tick();
      g++;
    end
    check("sweep_completes", 64'(ld_if.busy), 64'(0));
  endtask

  // Monitor: compares PE frames each sweep phase and every result strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!core_rst) begin
        n_tests++;
        if (exp_fq.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: core_rst low with no sweep expected");
        end else begin
          frame_t f;
          int     bad;
          f   = exp_fq.pop_front();
          bad = -1;
          for (int k = 15; k >= 0; k--)
            if (pre_w[k] !== f[k] || crt_w[k] !== f[16]) bad = k;
          if (bad >= 0) begin
            n_fail++;
            $display("FAIL frame_pe%0d (%0d phases left): got crt 0x%h pre 0x%h expected crt 0x%h pre 0x%h",
                     bad, exp_fq.size(), crt_w[bad], pre_w[bad], f[16], f[bad]);
          end
        end
      end else begin
        logic [63:0] acc_or;
        acc_or = '0;
        for (int k = 0; k < 16; k++) acc_or = acc_or | crt_w[k] | pre_w[k];
        n_tests++;
        if (acc_or !== 64'h0) begin
          n_fail++;
          $display("FAIL frames_idle_zero: got OR 0x%h expected 0x0", acc_or);
        end
      end
      if (ld_if.res_valid === 1'b1) begin
        n_tests++;
        if (exp_rq.size() == 0) begin
          n_fail++;
          $display("FAIL res_unexpected: res_valid high at cycle %0d", cyc);
        end else begin
          res_t e;
          e = exp_rq.pop_front();
          if (ld_if.res_sad !== e.sad || ld_if.res_mvx !== e.mvx ||
              ld_if.res_mvy !== e.mvy || 32'(cyc) !== e.cyc) begin
            n_fail++;
            $display("FAIL res: got sad 0x%h mvx %0d mvy %0d cyc %0d expected sad 0x%h mvx %0d mvy %0d cyc %0d",
                     ld_if.res_sad, ld_if.res_mvx, ld_if.res_mvy, cyc,
                     e.sad, e.mvx, e.mvy, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.start    = 1'b0;
    cfg_sad        = 14'h0123;
    cfg_mvx        = 4'd5;
    cfg_mvy        = 4'd9;
    #1 mon_en      = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("rst_busy", 64'(ld_if.busy), 64'(0));
    check("rst_core_rst", 64'(core_rst), 64'(1));
    check("rst_res_valid", 64'(ld_if.res_valid), 64'(0));
    check("rst_res_sad", 64'(ld_if.res_sad), 64'(0));
    check("rst_res_mv", 64'({ld_if.res_mvx, ld_if.res_mvy}), 64'(0));
    @(negedge clk) rst = 1'b0;
    tick();
    check("post_rst_ld_ready", 64'(ld_if.ld_ready), 64'(1));

    // Start while IDLE is ignored.
    ld_if.start = 1'b1;
    tick();
    ld_if.start = 1'b0;
    tick();
    check("idle_start_busy", 64'(ld_if.busy), 64'(0));
    check("idle_start_core_rst", 64'(core_rst), 64'(1));

    // Job A: continuous load, start ignored mid-load, hold ld_valid in FULL.
    fill_pattern(0);
    load_job(1'b0, 40);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) tick();
    check("full_hold_ld_ready", 64'(ld_if.ld_ready), 64'(0));
    check("full_hold_busy", 64'(ld_if.busy), 64'(1));
    ld_if.ld_valid = 1'b0;
    start_sweep(1'b1);
    check("ph0_crt_frame_5", crt_w[5], 64'h0101_0101_0101_0101);
    repeat (5) tick();
    ld_if.start = 1'b1;                       // start inside SWEEP: ignored
    tick();
    ld_if.start = 1'b0;
    repeat (3) tick();
    check("ph9_pre_frame_3", pre_w[3], 64'h6463_6261_605F_5E5D);
    wait_idle();
    check("done_res_valid", 64'(ld_if.res_valid), 64'(1));
    check("done_core_rst", 64'(core_rst), 64'(1));
    check("done_ld_ready", 64'(ld_if.ld_ready), 64'(1));
    tick();
    check("res_valid_one_cycle", 64'(ld_if.res_valid), 64'(0));
    repeat (3) tick();
    check("res_sad_hold", 64'(ld_if.res_sad), 64'h0123);

    // Job B: 50% ld_valid, new data, boundary result values.
    cfg_sad = 14'h3FFF;
    cfg_mvx = 4'hF;
    cfg_mvy = 4'h0;
    fill_pattern(1);
    load_job(1'b1, -1);
    start_sweep(1'b1);
    wait_idle();
    check("jobb_res_sad", 64'(ld_if.res_sad), 64'h3FFF);
    tick();

    // Job C: reset at phase 12 aborts the sweep with no result.
    fill_pattern(0);
    load_job(1'b0, -1);
    start_sweep(1'b0);
    repeat (12) tick();
    rst = 1'b1;
    exp_fq.delete();
    #2;
    check("abort_core_rst", 64'(core_rst), 64'(1));
    check("abort_crt_frame_0", crt_w[0], 64'h0);
    check("abort_pre_frame_7", pre_w[7], 64'h0);
    check("abort_res_valid", 64'(ld_if.res_valid), 64'(0));
    check("abort_res_sad", 64'(ld_if.res_sad), 64'h0);
    check("abort_busy", 64'(ld_if.busy), 64'(0));
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    tick();
    check("abort_release_ld_ready", 64'(ld_if.ld_ready), 64'(1));
    repeat (30) tick();

    check("frame_queue_drained", 64'(exp_fq.size()), 64'(0));
    check("res_queue_drained", 64'(exp_rq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
